// File: rtl/vid_box_overlay.sv
// vid_box_overlay
// Pixel-pipeline stage that follows the RGB channel-swap stage. It tracks the
// active-pixel position from the VDE/vsync timing, draws a rectangular border
// of a fixed colour onto the video and reports the measured line width and
// frame height. Box settings are sampled once per frame at the vsync rising
// edge, so the overlay can never tear mid-frame. Data and syncs see a fixed
// two-cycle latency; o_frame_start is a registered, undelayed pulse.
module vid_box_overlay #(
  parameter int DATA_WIDTH = 24,
  parameter int COORD_W    = 12,
  parameter int BORDER_W   = 2
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [DATA_WIDTH-1:0] i_vid_data,
  input  logic                  i_vid_hsync,
  input  logic                  i_vid_vsync,
  input  logic                  i_vid_VDE,
  input  logic [COORD_W-1:0]    i_box_x0,
  input  logic [COORD_W-1:0]    i_box_y0,
  input  logic [COORD_W-1:0]    i_box_x1,
  input  logic [COORD_W-1:0]    i_box_y1,
  input  logic [DATA_WIDTH-1:0] i_box_colour,
  input  logic                  i_enable,
  output logic [DATA_WIDTH-1:0] o_vid_data,
  output logic                  o_vid_hsync,
  output logic                  o_vid_vsync,
  output logic                  o_vid_VDE,
  output logic [COORD_W-1:0]    o_line_width,
  output logic [COORD_W-1:0]    o_frame_height,
  output logic                  o_frame_start
);

  localparam int                 CW1     = COORD_W + 1;
  localparam logic [COORD_W-1:0] CNT_MAX = '1;
  localparam logic [31:0]        BORDER  = 32'(BORDER_W);

  // Per-frame copy of the box settings
  typedef struct packed {
    logic [COORD_W-1:0]    x0;
    logic [COORD_W-1:0]    y0;
    logic [COORD_W-1:0]    x1;
    logic [COORD_W-1:0]    y1;
    logic [DATA_WIDTH-1:0] colour;
    logic                  en;
  } box_t;

  box_t               shadow_q, shadow_d;
  logic               vde_prev_q, vsync_prev_q;
  logic [COORD_W-1:0] x_cnt_q, x_cnt_d;
  logic [COORD_W-1:0] y_cnt_q, y_cnt_d;
  logic [COORD_W-1:0] line_width_q, line_width_d;
  logic [COORD_W-1:0] frame_height_q, frame_height_d;
  logic               frame_start_q;

  // Stage 1 and stage 2 pipeline registers
  logic [DATA_WIDTH-1:0] s1_data_q;
  logic                  s1_hsync_q, s1_vsync_q, s1_vde_q, s1_hit_q;
  logic [DATA_WIDTH-1:0] s2_data_q;
  logic                  s2_hsync_q, s2_vsync_q, s2_vde_q;

  logic               line_end, frame_begin;
  logic [COORD_W-1:0] y_inc;

  assign line_end    = vde_prev_q & ~i_vid_VDE;
  assign frame_begin = ~vsync_prev_q & i_vid_vsync;
  assign y_inc       = (y_cnt_q == CNT_MAX) ? y_cnt_q : y_cnt_q + 1'b1;

  // Hit test of the current pixel position against the shadow box. The
  // position itself is consumed here, so only the hit flag travels on.
  logic [CW1-1:0] x_w, y_w, x0_w, y0_w, x1_w, y1_w;
  logic [CW1-1:0] dx0, dx1, dy0, dy1;
  logic           in_box, near_edge, hit;

  assign x_w  = {1'b0, x_cnt_q};
  assign y_w  = {1'b0, y_cnt_q};
  assign x0_w = {1'b0, shadow_q.x0};
  assign y0_w = {1'b0, shadow_q.y0};
  assign x1_w = {1'b0, shadow_q.x1};
  assign y1_w = {1'b0, shadow_q.y1};
  assign dx0  = x_w - x0_w;
  assign dx1  = x1_w - x_w;
  assign dy0  = y_w - y0_w;
  assign dy1  = y1_w - y_w;

  // An inverted box (x0 > x1 or y0 > y1) can never satisfy in_box.
  assign in_box    = (x_w >= x0_w) && (x_w <= x1_w) && (y_w >= y0_w) && (y_w <= y1_w);
  assign near_edge = (32'(dx0) < BORDER) || (32'(dx1) < BORDER) ||
                     (32'(dy0) < BORDER) || (32'(dy1) < BORDER);
  assign hit       = shadow_q.en && in_box && near_edge;

  // Next-state for position counters, measurements and the shadow box
  // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    x_cnt_d        = x_cnt_q;
    y_cnt_d        = y_cnt_q;
    line_width_d   = line_width_q;
    frame_height_d = frame_height_q;
    shadow_d       = shadow_q;

    if (i_vid_VDE && (x_cnt_q != CNT_MAX)) begin
      x_cnt_d = x_cnt_q + 1'b1;
    end

    if (line_end) begin
      line_width_d = x_cnt_q;
      x_cnt_d      = '0;
      y_cnt_d      = y_inc;
    end

    // Frame start wins over end of line for y; a coincident line end still
    // counts toward the height.
    if (frame_begin) begin
      frame_height_d = line_end ? y_inc : y_cnt_q;
      y_cnt_d        = '0;
      x_cnt_d        = '0;
      shadow_d.x0     = i_box_x0;
      shadow_d.y0     = i_box_y0;
      shadow_d.x1     = i_box_x1;
      shadow_d.y1     = i_box_y1;
      shadow_d.colour = i_box_colour;
      shadow_d.en     = i_enable;
    end
  end

  // Control state: edge detectors, counters, measurements, shadow box
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      vde_prev_q     <= 1'b0;
      vsync_prev_q   <= 1'b0;
      x_cnt_q        <= '0;
      y_cnt_q        <= '0;
      line_width_q   <= '0;
      frame_height_q <= '0;
      frame_start_q  <= 1'b0;
      shadow_q       <= '0;
    end else begin
      vde_prev_q     <= i_vid_VDE;
      vsync_prev_q   <= i_vid_vsync;
      x_cnt_q        <= x_cnt_d;
      y_cnt_q        <= y_cnt_d;
      line_width_q   <= line_width_d;
      frame_height_q <= frame_height_d;
      frame_start_q  <= frame_begin;
      shadow_q       <= shadow_d;
    end
  end

  // Two-stage video pipeline: stage 1 captures pixel, syncs and hit flag,
  // stage 2 substitutes the overlay colour on active border pixels.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      s1_data_q  <= '0;
      s1_hsync_q <= 1'b0;
      s1_vsync_q <= 1'b0;
      s1_vde_q   <= 1'b0;
      s1_hit_q   <= 1'b0;
      s2_data_q  <= '0;
      s2_hsync_q <= 1'b0;
      s2_vsync_q <= 1'b0;
      s2_vde_q   <= 1'b0;
    end else begin
      s1_data_q  <= i_vid_data;
      s1_hsync_q <= i_vid_hsync;
      s1_vsync_q <= i_vid_vsync;
      s1_vde_q   <= i_vid_VDE;
      s1_hit_q   <= hit;
      s2_data_q  <= (s1_hit_q && s1_vde_q) ? shadow_q.colour : s1_data_q;
      s2_hsync_q <= s1_hsync_q;
      s2_vsync_q <= s1_vsync_q;
      s2_vde_q   <= s1_vde_q;
    end
  end

  assign o_vid_data     = s2_data_q;
  assign o_vid_hsync    = s2_hsync_q;
  assign o_vid_vsync    = s2_vsync_q;
  assign o_vid_VDE      = s2_vde_q;
  assign o_line_width   = line_width_q;
  assign o_frame_height = frame_height_q;
  assign o_frame_start  = frame_start_q;

endmodule

// File: tb/tb_vid_box_overlay.sv
// Testbench for vid_box_overlay: two instances (12-bit coordinates with a
// 1-pixel border, and 3-bit coordinates with a 2-pixel border) share one video
// stream. A behavioural model predicts every output sample from the frame
// row/column of each pixel and the box latched at each vsync rising edge.
module tb_vid_box_overlay;

  typedef struct packed {
    logic [23:0] d;
    logic        h;
    logic        v;
    logic        e;
  } vid_t;

  typedef struct packed {
    vid_t m;
    vid_t s;
    logic fs;
  } obs_t;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [23:0] vid_data = '0;
  logic        hs = 1'b0, vs = 1'b0, vde = 1'b0;
  logic [11:0] bx0 = '0, by0 = '0, bx1 = '0, by1 = '0;
  logic [23:0] bcol = '0;
  logic        ben = 1'b0;

  logic [23:0] o_data, s_data;
  logic        o_hs, o_vs, o_vde, o_fs, s_hs, s_vs, s_vde, s_fs;
  logic [11:0] o_lw, o_fh;
  logic [2:0]  s_lw, s_fh;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Scoreboard: one expected and one observed sample per clock
  obs_t exp_q[$];
  obs_t got_q[$];
  obs_t pend = '0;

  // Model of the box latched at the last vsync rising edge
  int          m_x0 = 0, m_y0 = 0, m_x1 = 0, m_y1 = 0;
  logic [23:0] m_col = '0;
  bit          m_en = 1'b0;
  bit          m_prev_v = 1'b0;

  // Staged box for a mid-frame change
  int nx0 = 0, ny0 = 0, nx1 = 0, ny1 = 0;

  always #5 clk = ~clk;

  vid_box_overlay #(.DATA_WIDTH(24), .COORD_W(12), .BORDER_W(1)) dut (
    .clk(clk), .n_rst(n_rst),
    .i_vid_data(vid_data), .i_vid_hsync(hs), .i_vid_vsync(vs), .i_vid_VDE(vde),
    .i_box_x0(bx0), .i_box_y0(by0), .i_box_x1(bx1), .i_box_y1(by1),
    .i_box_colour(bcol), .i_enable(ben),
    .o_vid_data(o_data), .o_vid_hsync(o_hs), .o_vid_vsync(o_vs), .o_vid_VDE(o_vde),
    .o_line_width(o_lw), .o_frame_height(o_fh), .o_frame_start(o_fs)
  );

  vid_box_overlay #(.DATA_WIDTH(24), .COORD_W(3), .BORDER_W(2)) dut_s (
    .clk(clk), .n_rst(n_rst),
    .i_vid_data(vid_data), .i_vid_hsync(hs), .i_vid_vsync(vs), .i_vid_VDE(vde),
    .i_box_x0(bx0[2:0]), .i_box_y0(by0[2:0]), .i_box_x1(bx1[2:0]), .i_box_y1(by1[2:0]),
    .i_box_colour(bcol), .i_enable(ben),
    .o_vid_data(s_data), .o_vid_hsync(s_hs), .o_vid_vsync(s_vs), .o_vid_VDE(s_vde),
    .o_line_width(s_lw), .o_frame_height(s_fh), .o_frame_start(s_fs)
  );

  // Border rule in plain integer arithmetic
  function automatic bit hit_f(int x, int y, int x0, int y0, int x1, int y1, int bw, bit en);
    if (!en || x < x0 || x > x1 || y < y0 || y > y1) return 1'b0;
    return (x - x0 < bw) || (x1 - x < bw) || (y - y0 < bw) || (y1 - y < bw);
  endfunction

  // One clock: predict, drive, advance, record
  task automatic cyc(input logic [23:0] d, input logic h, input logic v, input logic e,
                     input int r, input int c, input bit rst);
    obs_t now;
    bit   hm, hsm;
    int   xs, ys;
    now = rst ? obs_t'(0) : pend;
    now.fs = !rst && v && !m_prev_v;
    xs  = (c > 7) ? 7 : c;
    ys  = (r > 7) ? 7 : r;
    hm  = hit_f(c, r, m_x0, m_y0, m_x1, m_y1, 1, m_en);
    hsm = hit_f(xs, ys, m_x0 % 8, m_y0 % 8, m_x1 % 8, m_y1 % 8, 2, m_en);
    pend.m.d = (e && hm) ? m_col : d;
    pend.m.h = h; pend.m.v = v; pend.m.e = e;
    pend.s.d = (e && hsm) ? m_col : d;
    pend.s.h = h; pend.s.v = v; pend.s.e = e;
    pend.fs  = 1'b0;
    if (rst) begin
      pend = '0;
      m_en = 1'b0; m_x0 = 0; m_y0 = 0; m_x1 = 0; m_y1 = 0; m_col = '0; m_prev_v = 1'b0;
    end else begin
      if (v && !m_prev_v) begin
        m_x0 = int'(bx0); m_y0 = int'(by0); m_x1 = int'(bx1); m_y1 = int'(by1);
        m_col = bcol; m_en = ben;
      end
      m_prev_v = v;
    end
    vid_data = d; hs = h; vs = v; vde = e; n_rst = !rst;
    @(posedge clk);
    #1;
    exp_q.push_back(now);
    now.m.d = o_data; now.m.h = o_hs; now.m.v = o_vs; now.m.e = o_vde;
    now.s.d = s_data; now.s.h = s_hs; now.s.v = s_vs; now.s.e = s_vde;
    now.fs  = o_fs;
    got_q.push_back(now);
  endtask

  task automatic vsync_pulse();
    for (int i = 0; i < 2; i++) cyc(24'($urandom), 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 2; i++) cyc(24'($urandom), 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  // mode 0: constant bg, 1: sequential 1..w*h, 2: random
  task automatic send_rows(input int w, input int h, input int mode, input logic [23:0] bg,
                           input int chg_row, input bit sim_end);
    logic [23:0] pix;
    for (int r = 0; r < h; r++) begin
      for (int b = 0; b < 3; b++) cyc(24'($urandom), b < 2, 1'b0, 1'b0, 0, 0, 1'b0);
      for (int c = 0; c < w; c++) begin
        if (r == chg_row && c == w / 2) begin
          bx0 = 12'(nx0); by0 = 12'(ny0); bx1 = 12'(nx1); by1 = 12'(ny1);
        end
        case (mode)
          0:       pix = bg;
          1:       pix = 24'(r * w + c + 1);
          default: pix = 24'($urandom);
        endcase
        cyc(pix, 1'b0, 1'b0, 1'b1, r, c, 1'b0);
      end
    end
    if (!sim_end) cyc(24'($urandom), 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic set_box(input int x0, input int y0, input int x1, input int y1,
                         input logic [23:0] col, input bit en);
    bx0 = 12'(x0); by0 = 12'(y0); bx1 = 12'(x1); by1 = 12'(y1); bcol = col; ben = en;
  endtask

  task automatic test_reset();
    int mark;
    mark = exp_q.size();
    for (int i = 0; i < 2; i++) cyc(24'($urandom), 1'b1, 1'b1, 1'b1, 0, 0, 1'b1);
    chk_cnt++;
    if ({o_data, o_hs, o_vs, o_vde, o_lw, o_fh, o_fs} !== '0)
      $display("FAIL reset_main: got %h required 0", {o_data, o_hs, o_vs, o_vde, o_lw, o_fh, o_fs});
    else pass_cnt++;
    chk_cnt++;
    if ({s_data, s_hs, s_vs, s_vde, s_lw, s_fh, s_fs} !== '0)
      $display("FAIL reset_small: got %h required 0", {s_data, s_hs, s_vs, s_vde, s_lw, s_fh, s_fs});
    else pass_cnt++;
    for (int i = 0; i < 3; i++) cyc(24'($urandom), 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    for (int k = mark; k < exp_q.size(); k++) begin
      chk_cnt++;
      if (got_q[k] !== exp_q[k]) $display("FAIL reset_stream cycle %0d: got %h required %h", k, got_q[k], exp_q[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_latency();
    int mark;
    set_box(0, 0, 3, 2, 24'hFFFFFF, 1'b0);
    mark = exp_q.size();
    vsync_pulse();
    send_rows(4, 3, 1, '0, -1, 1'b0);
    chk_cnt++;
    if (o_lw !== 12'd4 || s_lw !== 3'd4) $display("FAIL latency_width: got %0d/%0d required 4/4", o_lw, s_lw);
    else pass_cnt++;
    vsync_pulse();
    chk_cnt++;
    if (o_fh !== 12'd3 || s_fh !== 3'd3) $display("FAIL latency_height: got %0d/%0d required 3/3", o_fh, s_fh);
    else pass_cnt++;
    for (int k = mark; k < exp_q.size(); k++) begin
      chk_cnt++;
      if (got_q[k] !== exp_q[k]) $display("FAIL latency_stream cycle %0d: got %h required %h", k, got_q[k], exp_q[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_border();
    int mark, red;
    set_box(2, 1, 5, 2, 24'hFF0000, 1'b1);
    mark = exp_q.size();
    vsync_pulse();
    send_rows(8, 4, 0, 24'h00FF00, -1, 1'b0);
    red = 0;
    for (int k = mark; k < got_q.size(); k++) if (got_q[k].m.e && got_q[k].m.d == 24'hFF0000) red++;
    chk_cnt++;
    if (red != 8) $display("FAIL border_count: got %0d red pixels required 8", red);
    else pass_cnt++;
    for (int k = mark; k < exp_q.size(); k++) begin
      chk_cnt++;
      if (got_q[k] !== exp_q[k]) $display("FAIL border_stream cycle %0d: got %h required %h", k, got_q[k], exp_q[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_frame_sync();
    int mark, m1, m2, red, fs_n;
    mark = exp_q.size();
    vsync_pulse();
    nx0 = 0; ny0 = 0; nx1 = 1; ny1 = 1;
    m1 = got_q.size();
    send_rows(8, 4, 0, 24'h00FF00, 2, 1'b0);
    red = 0;
    for (int k = m1; k < got_q.size(); k++) if (got_q[k].m.e && got_q[k].m.d == 24'hFF0000) red++;
    chk_cnt++;
    if (red != 8) $display("FAIL frame_sync_old: got %0d red pixels required 8", red);
    else pass_cnt++;
    m2 = got_q.size();
    vsync_pulse();
    fs_n = 0;
    for (int k = m2; k < got_q.size(); k++) if (got_q[k].fs) fs_n++;
    chk_cnt++;
    if (fs_n != 1) $display("FAIL frame_sync_pulse: got %0d pulses required 1", fs_n);
    else pass_cnt++;
    m1 = got_q.size();
    send_rows(8, 4, 0, 24'h00FF00, -1, 1'b0);
    red = 0;
    for (int k = m1; k < got_q.size(); k++) if (got_q[k].m.e && got_q[k].m.d == 24'hFF0000) red++;
    chk_cnt++;
    if (red != 4) $display("FAIL frame_sync_new: got %0d red pixels required 4", red);
    else pass_cnt++;
    for (int k = mark; k < exp_q.size(); k++) begin
      chk_cnt++;
      if (got_q[k] !== exp_q[k]) $display("FAIL frame_sync_stream cycle %0d: got %h required %h", k, got_q[k], exp_q[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_invalid();
    int mark, red;
    set_box(6, 0, 3, 3, 24'hFF0000, 1'b1);
    mark = exp_q.size();
    vsync_pulse();
    send_rows(8, 4, 0, 24'h00FF00, -1, 1'b0);
    red = 0;
    for (int k = mark; k < got_q.size(); k++) if (got_q[k].m.e && got_q[k].m.d !== 24'h00FF00) red++;
    chk_cnt++;
    if (red != 0) $display("FAIL invalid_box: got %0d modified pixels required 0", red);
    else pass_cnt++;
    for (int k = mark; k < exp_q.size(); k++) begin
      chk_cnt++;
      if (got_q[k] !== exp_q[k]) $display("FAIL invalid_stream cycle %0d: got %h required %h", k, got_q[k], exp_q[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_simultaneous();
    int mark;
    set_box(1, 1, 3, 2, 24'h123456, 1'b1);
    mark = exp_q.size();
    vsync_pulse();
    send_rows(5, 4, 2, '0, -1, 1'b1);
    vsync_pulse();
    chk_cnt++;
    if (o_fh !== 12'd4 || s_fh !== 3'd4) $display("FAIL simultaneous_height: got %0d/%0d required 4/4", o_fh, s_fh);
    else pass_cnt++;
    chk_cnt++;
    if (o_lw !== 12'd5 || s_lw !== 3'd5) $display("FAIL simultaneous_width: got %0d/%0d required 5/5", o_lw, s_lw);
    else pass_cnt++;
    for (int k = mark; k < exp_q.size(); k++) begin
      chk_cnt++;
      if (got_q[k] !== exp_q[k]) $display("FAIL simultaneous_stream cycle %0d: got %h required %h", k, got_q[k], exp_q[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_saturation();
    int mark;
    set_box(4, 4, 7, 7, 24'h00AA55, 1'b1);
    mark = exp_q.size();
    vsync_pulse();
    send_rows(10, 9, 2, '0, -1, 1'b0);
    chk_cnt++;
    if (o_lw !== 12'd10 || s_lw !== 3'd7) $display("FAIL saturation_width: got %0d/%0d required 10/7", o_lw, s_lw);
    else pass_cnt++;
    vsync_pulse();
    chk_cnt++;
    if (o_fh !== 12'd9 || s_fh !== 3'd7) $display("FAIL saturation_height: got %0d/%0d required 9/7", o_fh, s_fh);
    else pass_cnt++;
    for (int k = mark; k < exp_q.size(); k++) begin
      chk_cnt++;
      if (got_q[k] !== exp_q[k]) $display("FAIL saturation_stream cycle %0d: got %h required %h", k, got_q[k], exp_q[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    int mark, m1, red;
    set_box(0, 0, 7, 3, 24'h0000FF, 1'b1);
    mark = exp_q.size();
    vsync_pulse();
    send_rows(8, 1, 0, 24'h808080, -1, 1'b1);
    for (int b = 0; b < 3; b++) cyc(24'($urandom), b < 2, 1'b0, 1'b0, 0, 0, 1'b0);
    for (int c = 0; c < 3; c++) cyc(24'h808080, 1'b0, 1'b0, 1'b1, 1, c, 1'b0);
    m1 = got_q.size();
    cyc(24'h808080, 1'b0, 1'b0, 1'b1, 1, 3, 1'b1);
    chk_cnt++;
    if ({o_data, o_hs, o_vs, o_vde, o_lw, o_fh, o_fs, s_data, s_lw, s_fh} !== '0)
      $display("FAIL reset_mid_outputs: got %h required 0",
               {o_data, o_hs, o_vs, o_vde, o_lw, o_fh, o_fs, s_data, s_lw, s_fh});
    else pass_cnt++;
    for (int c = 4; c < 8; c++) cyc(24'h808080, 1'b0, 1'b0, 1'b1, 1, c, 1'b0);
    cyc(24'($urandom), 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    chk_cnt++;
    if (o_lw !== 12'd4 || s_lw !== 3'd4) $display("FAIL reset_mid_width: got %0d/%0d required 4/4", o_lw, s_lw);
    else pass_cnt++;
    red = 0;
    for (int k = m1; k < got_q.size(); k++) if (got_q[k].m.e && got_q[k].m.d == 24'h0000FF) red++;
    chk_cnt++;
    if (red != 0) $display("FAIL reset_mid_overlay: got %0d overlay pixels required 0", red);
    else pass_cnt++;
    vsync_pulse();
    chk_cnt++;
    if (o_fh !== 12'd1 || s_fh !== 3'd1) $display("FAIL reset_mid_height: got %0d/%0d required 1/1", o_fh, s_fh);
    else pass_cnt++;
    send_rows(8, 4, 0, 24'h808080, -1, 1'b0);
    for (int k = mark; k < exp_q.size(); k++) begin
      chk_cnt++;
      if (got_q[k] !== exp_q[k]) $display("FAIL reset_mid_stream cycle %0d: got %h required %h", k, got_q[k], exp_q[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    int  mark, w, h, prev_h;
    bit  sim;
    mark   = exp_q.size();
    prev_h = 0;
    for (int i = 0; i < 8; i++) begin
      set_box($urandom_range(0, 12), $urandom_range(0, 8), $urandom_range(0, 15),
              $urandom_range(0, 11), 24'($urandom), $urandom_range(0, 3) != 0);
      vsync_pulse();
      if (i > 0) begin
        chk_cnt++;
        if (o_fh !== 12'(prev_h) || s_fh !== 3'((prev_h > 7) ? 7 : prev_h))
          $display("FAIL random_height frame %0d: got %0d/%0d required %0d", i, o_fh, s_fh, prev_h);
        else pass_cnt++;
      end
      w   = $urandom_range(4, 14);
      h   = $urandom_range(3, 10);
      sim = $urandom_range(0, 1) != 0;
      send_rows(w, h, 2, '0, -1, sim);
      if (!sim) begin
        chk_cnt++;
        if (o_lw !== 12'(w) || s_lw !== 3'((w > 7) ? 7 : w))
          $display("FAIL random_width frame %0d: got %0d/%0d required %0d", i, o_lw, s_lw, w);
        else pass_cnt++;
      end
      prev_h = h;
    end
    vsync_pulse();
    for (int k = mark; k < exp_q.size(); k++) begin
      chk_cnt++;
      if (got_q[k] !== exp_q[k]) $display("FAIL random_stream cycle %0d: got %h required %h", k, got_q[k], exp_q[k]);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_border();
    test_frame_sync();
    test_invalid();
    test_simultaneous();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
